// File: rtl/npu_mac_array.sv
// npu_mac_array: NUM_PE-lane bus-fed MAC engine with operand FIFO, sequencer, shift/ReLU/saturate; define NPU_BIAS_EN for per-lane bias preload
module npu_mac_array #(
    parameter int NUM_PE     = 4,
    parameter int DW         = 8,
    parameter int ACC_W      = 24,
    parameter int LEN_W      = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic        wea,
    input  logic [15:0] addra,
    input  logic [31:0] dina,
    output logic [31:0] douta,
    output logic        busy,
    output logic        done
);
    localparam int PW = NUM_PE * DW;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = NUM_PE > 1 ? $clog2(NUM_PE) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

    state_t                   state_q, state_d;
    logic [LEN_W-1:0]         cnt_q, cnt_d, len_q;
    logic                     sact_q, relu_q, ovf_q, ovf_d, busy_q, done_q;
    logic [2:0]               shift_q;
    logic [PW-1:0]            stage_q, res_pack;
    logic [2*PW-1:0]          mem_q [FIFO_DEPTH];
    logic [2*PW-1:0]          head;
    logic [AW-1:0]            wp_q, rp_q;
    logic [AW:0]              count_q, count_d;
    logic signed [ACC_W-1:0]  acc_q [NUM_PE];
    logic signed [ACC_W-1:0]  acc_d [NUM_PE];
    logic signed [ACC_W-1:0]  pre [NUM_PE];
    logic signed [ACC_W-1:0]  prod [NUM_PE];
    logic [DW-1:0]            res_q [NUM_PE];
    logic [DW-1:0]            res_d [NUM_PE];
    logic [DW-1:0]            sat [NUM_PE];
    logic [31:0]              douta_q, rdata, status;
    logic [2:0]               sel;
    logic [3:0]               lane;
    logic [LW-1:0]            lane_i;
    logic                     wr, rd, push, push_ok, pop, full, start, clear, lane_ok;
    logic                     unused_bits;

    assign sel         = addra[14:12];
    assign lane        = addra[3:0];
    assign lane_i      = lane[LW-1:0];
    assign lane_ok     = {1'b0, lane} < 5'(NUM_PE);
    assign unused_bits = ^{addra[15], addra[11:4]};
    assign wr          = ena & wea;
    assign rd          = ena & ~wea;
    assign clear       = wr && sel == 3'b100 && dina[1];
    assign start       = wr && sel == 3'b100 && dina[0] && !dina[1];
    assign push        = wr && sel == 3'b010;
    assign full        = count_q == (AW+1)'(FIFO_DEPTH);
    assign pop         = state_q == S_RUN && count_q != '0;
    assign push_ok     = push && (!full || pop);
    assign count_d     = clear ? '0 : count_q + (AW+1)'(push_ok) - (AW+1)'(pop);
    assign head        = mem_q[rp_q];
    assign busy        = busy_q;
    assign done        = done_q;
    assign douta       = douta_q;

    for (genvar i = 0; i < NUM_PE; i++) begin : g_lane
        logic [DW-1:0]           a, w;
        logic signed [2*DW:0]    p;
        logic signed [ACC_W-1:0] sh, rl;
        assign a  = head[PW + i*DW +: DW];
        assign w  = head[i*DW +: DW];
        assign p  = (2*DW+1)'($signed({sact_q & a[DW-1], a})) * (2*DW+1)'($signed(w));
        assign prod[i] = ACC_W'(p);
        assign sh = acc_q[i] >>> shift_q;
        assign rl = (relu_q && sh[ACC_W-1]) ? '0 : sh;
        // in range iff every bit from the result sign bit upward agrees
        assign sat[i] = (&rl[ACC_W-1:DW-1] || ~|rl[ACC_W-1:DW-1]) ? rl[DW-1:0]
                      : {rl[ACC_W-1], {(DW-1){~rl[ACC_W-1]}}};
        assign res_pack[i*DW +: DW] = res_q[i];
    end

`ifdef NPU_BIAS_EN
    logic signed [ACC_W-1:0] bias_q [NUM_PE];
    always_ff @(posedge clk) begin
        if (rst)
            bias_q <= '{default: '0};
        else if (wr && sel == 3'b000 && lane_ok)
            bias_q[lane_i] <= dina[ACC_W-1:0];
    end
    always_comb pre = bias_q;
`else
    always_comb pre = '{default: '0};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE, S_FIN: if (start) begin
                state_d = len_q == '0 ? S_DRAIN : S_RUN;
                cnt_d   = '0;
                acc_d   = pre;
            end
            S_RUN: if (pop) begin
                cnt_d = cnt_q + 1'b1;
                for (int i = 0; i < NUM_PE; i++) acc_d[i] = acc_q[i] + prod[i];
                if (cnt_q + 1'b1 == len_q) state_d = S_DRAIN;
            end
            default: begin
                res_d   = sat;
                state_d = S_FIN;
            end
        endcase
        if (clear) begin
            state_d = S_IDLE;
            acc_d   = '{default: '0};
            res_d   = '{default: '0};
            ovf_d   = 1'b0;
        end else if (push && full && !pop) begin
            ovf_d = 1'b1;
        end
    end

    assign status = {23'b0, ovf_q, 4'(count_q), 2'b0, busy_q, done_q};

    always_comb
        rdata = sel == 3'b101 ? status
              : sel == 3'b110 ? 32'(res_pack)
              : (sel == 3'b111 && lane_ok) ? 32'(acc_q[lane_i]) : '0;

    always_ff @(posedge clk)
        if (push_ok && !clear) mem_q[wp_q] <= {stage_q, dina[PW-1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            sact_q  <= 1'b0;
            relu_q  <= 1'b0;
            shift_q <= '0;
            stage_q <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            douta_q <= '0;
            acc_q   <= '{default: '0};
            res_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            count_q <= count_d;
            busy_q  <= state_d == S_RUN || state_d == S_DRAIN;
            done_q  <= state_d == S_FIN;
            if (wr && sel == 3'b001) stage_q <= dina[PW-1:0];
            if (wr && sel == 3'b011 && !busy_q) begin
                len_q   <= dina[LEN_W-1:0];
                sact_q  <= dina[16];
                relu_q  <= dina[17];
                shift_q <= dina[20:18];
            end
            if (clear) begin
                wp_q <= '0;
                rp_q <= '0;
            end else begin
                if (push_ok) wp_q <= wp_q + 1'b1;
                if (pop) rp_q <= rp_q + 1'b1;
            end
            if (rd) douta_q <= rdata;
        end
    end
endmodule

// File: tb/tb_npu_mac_array.sv
// tb_npu_mac_array: directed scoreboard bench; register reads queue expectations that a monitor checks one cycle later
module tb_npu_mac_array;
    logic        clk = 1'b0, rst = 1'b1, ena = 1'b0, wea = 1'b0;
    logic [15:0] addra = '0;
    logic [31:0] dina = '0;
    logic [31:0] douta;
    logic        busy, done;
    logic        pend = 1'b0;
    int          checks = 0, passes = 0;
    logic [31:0] exp_q[$];
    string       nm_q[$];

    npu_mac_array dut (
        .clk(clk), .rst(rst), .ena(ena), .wea(wea), .addra(addra),
        .dina(dina), .douta(douta), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) pend <= ena & ~wea & ~rst;

    always @(negedge clk) begin
        if (pend) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_read: douta=%h with no expected value queued", douta);
            end else begin
                logic [31:0] e;
                string n;
                e = exp_q.pop_front();
                n = nm_q.pop_front();
                if (douta === e) passes++;
                else $display("FAIL %s: douta=%h expected %h", n, douta, e);
            end
        end
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] e);
        checks++;
        if (act === e) passes++;
        else $display("FAIL %s: got %h expected %h", n, act, e);
    endtask

    task automatic bus_wr(input logic [2:0] s, input logic [3:0] l, input logic [31:0] d);
        ena = 1'b1; wea = 1'b1; addra = {1'b0, s, 8'h00, l}; dina = d;
        @(negedge clk);
        ena = 1'b0; wea = 1'b0;
    endtask

    task automatic bus_rd(input string n, input logic [2:0] s, input logic [3:0] l, input logic [31:0] e);
        exp_q.push_back(e);
        nm_q.push_back(n);
        ena = 1'b1; wea = 1'b0; addra = {1'b0, s, 8'h00, l};
        @(negedge clk);
        ena = 1'b0;
    endtask

    task automatic wait_done(input string n);
        int k = 0;
        while (!done && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk(n, {31'b0, done}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        bus_rd("rst_status", 3'b101, 0, 32'h0);
        bus_rd("rst_results", 3'b110, 0, 32'h0);
        bus_rd("other_sel", 3'b000, 0, 32'h0);

        bus_wr(3'b011, 0, 32'd3);
        bus_wr(3'b001, 0, 32'h0A0A0A0A);
        bus_wr(3'b010, 0, 32'h0000FB01);
        bus_wr(3'b010, 0, 32'h0000FB02);
        bus_wr(3'b010, 0, 32'h0000FB03);
        bus_rd("status_cnt3", 3'b101, 0, 32'h30);
        bus_wr(3'b100, 0, 32'd1);
        wait_done("basic_done");
        bus_rd("basic_results", 3'b110, 0, 32'h0000803C);
        bus_rd("basic_acc0", 3'b111, 0, 32'd60);
        bus_rd("basic_acc1", 3'b111, 1, 32'hFFFFFF6A);
        bus_rd("acc_lane_oor", 3'b111, 5, 32'h0);
        bus_rd("basic_status", 3'b101, 0, 32'h1);

        bus_wr(3'b011, 0, 32'h000A0003);
        bus_wr(3'b010, 0, 32'h0000FB01);
        bus_wr(3'b010, 0, 32'h0000FB02);
        bus_wr(3'b010, 0, 32'h0000FB03);
        bus_wr(3'b100, 0, 32'd1);
        wait_done("relu_done");
        bus_rd("relu_results", 3'b110, 0, 32'h0000000F);
        bus_rd("relu_acc1", 3'b111, 1, 32'hFFFFFF6A);

        bus_wr(3'b100, 0, 32'd2);
        chk("clear_done", {31'b0, done}, 0);
        bus_rd("clear_results", 3'b110, 0, 32'h0);
        for (int i = 0; i < 5; i++) bus_wr(3'b010, 0, 32'h01010101);
        bus_rd("overflow_status", 3'b101, 0, 32'h140);
        bus_wr(3'b100, 0, 32'd3);
        bus_rd("clear2_status", 3'b101, 0, 32'h0);

        bus_wr(3'b011, 0, 32'd4);
        bus_wr(3'b010, 0, 32'h01010101);
        bus_wr(3'b010, 0, 32'h01010101);
        bus_wr(3'b100, 0, 32'd1);
        repeat (6) @(negedge clk);
        chk("stall_busy", {31'b0, busy}, 1);
        bus_rd("stall_status", 3'b101, 0, 32'h2);
        bus_rd("stall_acc0", 3'b111, 0, 32'd20);
        bus_wr(3'b010, 0, 32'h01010101);
        bus_wr(3'b010, 0, 32'h01010101);
        chk("stall_not_done", {31'b0, done}, 0);
        @(negedge clk);
        chk("stall_drain_busy", {31'b0, busy}, 1);
        @(negedge clk);
        chk("stall_done", {busy, done}, 32'h1);
        bus_rd("stall_results", 3'b110, 0, 32'h28282828);

        bus_wr(3'b001, 0, 32'h000000FF);
        bus_wr(3'b011, 0, 32'h00010001);
        bus_wr(3'b010, 0, 32'h00000005);
        bus_wr(3'b100, 0, 32'd1);
        wait_done("sact_done");
        bus_rd("sact_acc0", 3'b111, 0, 32'hFFFFFFFB);
        bus_rd("sact_results", 3'b110, 0, 32'h000000FB);
        bus_wr(3'b011, 0, 32'h00000001);
        bus_wr(3'b010, 0, 32'h00000005);
        bus_wr(3'b100, 0, 32'd1);
        wait_done("uact_done");
        bus_rd("uact_acc0", 3'b111, 0, 32'h000004FB);
        bus_rd("uact_results", 3'b110, 0, 32'h0000007F);

        bus_wr(3'b011, 0, 32'd0);
`ifdef NPU_BIAS_EN
        bus_wr(3'b000, 0, 32'd300);
`endif
        bus_wr(3'b100, 0, 32'd1);
        chk("len0_drain", {busy, done}, 32'h2);
        @(negedge clk);
        chk("len0_done", {busy, done}, 32'h1);
`ifdef NPU_BIAS_EN
        bus_rd("len0_results", 3'b110, 0, 32'h0000007F);
`else
        bus_rd("len0_results", 3'b110, 0, 32'h0);
`endif

        bus_wr(3'b011, 0, 32'd8);
        for (int i = 0; i < 3; i++) bus_wr(3'b010, 0, 32'h00000001);
        bus_wr(3'b100, 0, 32'd1);
        repeat (5) @(negedge clk);
        chk("midrun_busy", {31'b0, busy}, 1);
        bus_rd("midrun_acc0", 3'b111, 0, 32'd765);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rerst_flags", {busy, done}, 32'h0);
        bus_rd("rerst_status", 3'b101, 0, 32'h0);
        bus_rd("rerst_results", 3'b110, 0, 32'h0);
        bus_rd("rerst_acc0", 3'b111, 0, 32'h0);

        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() == 0) passes++;
        else $display("FAIL scoreboard_drain: %0d reads left unchecked, expected 0", exp_q.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
